// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and constants for the scan chain controller: FSM state encoding,
// shift/functional scan-enable levels, serial fill value and counter sizing.
package scan_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    CAPTURE   = 2'd2,
    SHIFT_OUT = 2'd3
  } state_t;

  localparam logic SE_SHIFT = 1'b1;
  localparam logic SE_FUNC  = 1'b0;
  localparam logic SI_FILL  = 1'b0;

  function automatic int unsigned calc_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_shreg.sv
// Register with parallel load and a right shift: bit 0 leaves as serial out,
// the serial input enters at the MSB.
module scan_chain_ctrl_shreg
  import scan_chain_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Load has priority over shift; otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequences shift-in / capture / shift-out of one mux-D scan chain.
// Optional on-the-fly response compare: define SCAN_CHAIN_CTRL_COMPARE_EN.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN      = 32,
  parameter int unsigned CAPTURE_CYCLES = 1,
  localparam int unsigned CNT_W         = calc_cnt_w(CHAIN_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CHAIN_LEN-1:0] i_pattern,
  input  logic                 i_so,
  output logic                 o_se,
  output logic                 o_si,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CHAIN_LEN-1:0] o_resp
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  ,
  input  logic [CHAIN_LEN-1:0] i_expect,
  input  logic [CHAIN_LEN-1:0] i_mask,
  output logic                 o_fail,
  output logic [CNT_W-1:0]     o_fail_cnt
`endif
);

  // The phase counter must also hold CAPTURE_CYCLES-1, which may exceed CHAIN_LEN.
  localparam int unsigned TMR_MAX = (CAPTURE_CYCLES > CHAIN_LEN) ? CAPTURE_CYCLES : CHAIN_LEN;
  localparam int unsigned TMR_W   = calc_cnt_w(TMR_MAX);
  localparam logic [TMR_W-1:0] SHIFT_LOAD = TMR_W'(CHAIN_LEN - 1);
  localparam logic [TMR_W-1:0] CAP_LOAD   = TMR_W'(CAPTURE_CYCLES - 1);
  localparam logic [TMR_W-1:0] CNT_ZERO   = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] CNT_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [CHAIN_LEN-1:0] FILL_VEC = {CHAIN_LEN{SI_FILL}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_cnt;
  logic [TMR_W-1:0]   w_cnt_nxt;
  logic               r_se;
  logic               r_busy;
  logic               r_done;
  logic               w_se_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_accept;
  logic               w_pat_load;
  logic               w_pat_shift;
  logic               w_resp_shift;
  logic [CHAIN_LEN-1:0] w_pat_load_val;
  logic [CHAIN_LEN-1:0] w_pat_q;
  logic [CHAIN_LEN-1:0] w_resp_q;
  logic               w_pat_hi_unused;

  // Next state, phase counter and next registered output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_se_nxt     = SE_FUNC;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_accept     = 1'b0;
    w_pat_load   = 1'b0;
    w_pat_shift  = 1'b0;
    w_resp_shift = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_accept    = 1'b1;
          w_pat_load  = 1'b1;
          w_state_nxt = SHIFT_IN;
          w_cnt_nxt   = SHIFT_LOAD;
          w_se_nxt    = SE_SHIFT;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT_IN: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
          w_pat_load  = 1'b1;
        end else begin
          w_pat_shift = 1'b1;
          w_busy_nxt  = 1'b1;
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = CAPTURE;
            w_cnt_nxt   = CAP_LOAD;
            w_se_nxt    = SE_FUNC;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            w_se_nxt  = SE_SHIFT;
          end
        end
      end
      CAPTURE: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
          w_pat_load  = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = SHIFT_OUT;
            w_cnt_nxt   = SHIFT_LOAD;
            w_se_nxt    = SE_SHIFT;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            w_se_nxt  = SE_FUNC;
          end
        end
      end
      SHIFT_OUT: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
          w_pat_load  = 1'b1;
        end else begin
          w_resp_shift = 1'b1;
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt - CNT_ONE;
            w_se_nxt   = SE_SHIFT;
            w_busy_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // An abort reloads the pattern register with fill so SI drops to the fill value.
  assign w_pat_load_val = w_accept ? i_pattern : FILL_VEC;

  // State, counter and control outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
      r_se    <= SE_FUNC;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_se    <= w_se_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Pattern bit 0 drives SI directly; the register drains to fill after N shifts.
  scan_chain_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_pat_shreg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_pat_load),
    .i_load_val (w_pat_load_val),
    .i_shift    (w_pat_shift),
    .i_sin      (SI_FILL),
    .o_q        (w_pat_q)
  );

  // Response is cleared on accept; SO enters at the MSB so sample k lands at bit k.
  scan_chain_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_resp_shreg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_load_val (FILL_VEC),
    .i_shift    (w_resp_shift),
    .i_sin      (i_so),
    .o_q        (w_resp_q)
  );

  assign w_pat_hi_unused = |w_pat_q[CHAIN_LEN-1:1];

  assign o_se   = r_se;
  assign o_si   = w_pat_q[0];
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_resp = w_resp_q;

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  localparam logic [CNT_W-1:0] FAIL_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] FAIL_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FAIL_MAX  = {CNT_W{1'b1}};

  logic [CHAIN_LEN-1:0] r_expect;
  logic [CHAIN_LEN-1:0] r_mask;
  logic [CNT_W-1:0]     r_fail_cnt;
  logic [CNT_W-1:0]     w_fail_cnt_nxt;
  logic                 r_fail;
  logic                 w_bit_miss;

  // Expect/mask shift alongside the response so bit 0 always matches the current SO.
  always_comb begin
    w_bit_miss = (i_so != r_expect[0]) && !r_mask[0];
    if (w_resp_shift && w_bit_miss && (r_fail_cnt != FAIL_MAX)) begin
      w_fail_cnt_nxt = r_fail_cnt + FAIL_ONE;
    end else begin
      w_fail_cnt_nxt = r_fail_cnt;
    end
  end

  // Compare state: latched at accept, advanced per shift-out bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_expect   <= {CHAIN_LEN{1'b0}};
      r_mask     <= {CHAIN_LEN{1'b0}};
      r_fail_cnt <= FAIL_ZERO;
      r_fail     <= 1'b0;
    end else if (w_accept) begin
      r_expect   <= i_expect;
      r_mask     <= i_mask;
      r_fail_cnt <= FAIL_ZERO;
      r_fail     <= 1'b0;
    end else if (w_resp_shift) begin
      r_expect   <= {1'b0, r_expect[CHAIN_LEN-1:1]};
      r_mask     <= {1'b0, r_mask[CHAIN_LEN-1:1]};
      r_fail_cnt <= w_fail_cnt_nxt;
      r_fail     <= (w_fail_cnt_nxt != FAIL_ZERO);
    end else begin
      r_expect   <= r_expect;
      r_mask     <= r_mask;
      r_fail_cnt <= r_fail_cnt;
      r_fail     <= r_fail;
    end
  end

  assign o_fail     = r_fail;
  assign o_fail_cnt = r_fail_cnt;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl driving an 8-flop mux-D scan chain model.
module tb_scan_chain_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic       so;
  logic       se;
  logic       si;
  logic       busy;
  logic       done;
  logic [7:0] resp;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  logic [7:0] expect_v;
  logic [7:0] mask_v;
  logic       fail;
  logic [3:0] fail_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] chain;
  logic       tie_mode;
  logic       got;

  typedef struct {
    logic [7:0] pat;
    logic       tie;
    logic       hold_start;
    logic [7:0] exp_resp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_abort   (abort),
    .i_pattern (pattern),
    .i_so      (so),
    .o_se      (se),
    .o_si      (si),
    .o_busy    (busy),
    .o_done    (done),
    .o_resp    (resp)
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    ,
    .i_expect  (expect_v),
    .i_mask    (mask_v),
    .o_fail    (fail),
    .o_fail_cnt(fail_cnt)
`endif
  );

  // Chain of mux-D scan flops: flop 0 fed by SI, flop 7 drives SO.
  always @(posedge clk) begin
    if (rst) chain <= 8'h00;
    else if (se) chain <= {chain[6:0], si};
    else if (tie_mode) chain <= 8'h3C;
    else chain <= chain;
  end
  assign so = chain[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input logic [7:0] pat, input logic tie, input logic hold,
                         input logic [7:0] exp_resp);
    logic [16:0] se_seq;
    logic        busy_all;
    int          lat;
    logic        seen;
    @(negedge clk);
    pattern  = pat;
    tie_mode = tie;
    start    = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    se_seq   = 17'h0;
    busy_all = 1'b1;
    lat      = 0;
    seen     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = c + 1;
        break;
      end
      if (c < 17) se_seq[c[4:0]] = se;
      busy_all = busy_all & busy;
      pattern  = ~pattern;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'd18);
    check("se_sequence", 32'(se_seq), 32'h1FEFF);
    check("busy_during", 32'(busy_all), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("se_at_done", 32'(se), 32'd0);
    check("resp", 32'(resp), 32'(exp_resp));
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 8'h3C};
    vecs[2] = '{8'h5A, 1'b0, 1'b1, 8'h5A};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h3C};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h81};
    vecs[5] = '{8'h12, 1'b1, 1'b1, 8'h3C};

    rst      = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    pattern  = 8'hA5;
    tie_mode = 1'b0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    expect_v = 8'h00;
    mask_v   = 8'h00;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_se", 32'(se), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_resp", 32'(resp), 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_vec(vecs[v].pat, vecs[v].tie, vecs[v].hold_start, vecs[v].exp_resp);
    end

    // Abort during shift-in cycle 4, restart one cycle later.
    @(negedge clk);
    pattern  = 8'hC3;
    tie_mode = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_se", 32'(se), 32'd0);
    check("abort_si", 32'(si), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    start   = 1'b1;
    pattern = 8'h96;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_se", 32'(se), 32'd1);
    check("restart_no_done", 32'(done), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("restart_done_seen", 32'(got), 32'd1);
    check("restart_resp", 32'(resp), 32'h96);
    @(negedge clk);

    // Abort while in capture.
    pattern = 8'h3E;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("capture_se", 32'(se), 32'd0);
    check("capture_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cap_busy", 32'(busy), 32'd0);
    check("abort_cap_se", 32'(se), 32'd0);

    // Abort during shift-out: no DONE may follow.
    pattern = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_out_busy", 32'(busy), 32'd0);
    check("abort_out_se", 32'(se), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done !== 1'b0) got = 1'b1;
      @(negedge clk);
    end
    check("abort_out_no_done", 32'(got), 32'd0);

    // START and ABORT together in IDLE: nothing starts.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_se", 32'(se), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy2", 32'(busy), 32'd0);

    // Reset mid shift-out clears everything including RESP.
    pattern = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_resp", 32'(resp), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_se", 32'(se), 32'd0);
    check("midrst_done", 32'(done), 32'd0);

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    expect_v = 8'hA5;
    mask_v   = 8'h00;
    run_vec(8'hA4, 1'b0, 1'b0, 8'hA4);
    check("cmp_fail", 32'(fail), 32'd1);
    check("cmp_fail_cnt", 32'(fail_cnt), 32'd1);
    mask_v = 8'h01;
    run_vec(8'hA4, 1'b0, 1'b0, 8'hA4);
    check("cmp_masked_fail", 32'(fail), 32'd0);
    check("cmp_masked_cnt", 32'(fail_cnt), 32'd0);
    mask_v = 8'h00;
    run_vec(8'h5A, 1'b0, 1'b0, 8'h5A);
    check("cmp_all_fail", 32'(fail), 32'd1);
    check("cmp_all_cnt", 32'(fail_cnt), 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
